// File: rtl/calc_key_ctrl_pkg.sv
// Shared constants for the keypad calculator: ASCII codes, key map, size defaults
// and the evaluator state encoding.
package calc_key_ctrl_pkg;

  localparam int STR_LEN_DEF = 32;
  localparam int RES_W_DEF   = 24;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_B     = 8'h42;

  // Indexed [row][col], row 0 at the top of the keypad.
  localparam logic [7:0] KEY_MAP [4][4] = '{
    '{8'h31, 8'h32, 8'h33, CH_PLUS },
    '{8'h34, 8'h35, 8'h36, CH_MINUS},
    '{8'h37, 8'h38, 8'h39, CH_MUL  },
    '{CH_C,  CH_0,  CH_EQ, CH_B    }
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } eval_state_e;

  function automatic logic [7:0] key_at(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[row][col];
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/calc_eval.sv
// Left-to-right, no-precedence expression evaluator; fetches one buffer char per
// cycle and produces an unsigned RES_W-bit result.
module calc_eval
  import calc_key_ctrl_pkg::*;
#(
  parameter  int STR_LEN = STR_LEN_DEF,
  parameter  int RES_W   = RES_W_DEF,
  localparam int LEN_W   = $clog2(STR_LEN + 1),
  localparam int IDX_W   = (STR_LEN > 1) ? $clog2(STR_LEN) : 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic             clear_res,
  input  logic             clear_done,
  input  logic [LEN_W-1:0] len_in,
  output logic [IDX_W-1:0] fetch_idx,
  input  logic [7:0]       fetch_char,
  output logic [RES_W-1:0] result,
  output logic             done,
  output logic             busy
);

  eval_state_e      state_q;
  logic [RES_W-1:0] acc_q;
  logic [RES_W-1:0] operand_q;
  logic [7:0]       pend_op_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic [RES_W-1:0] result_q;
  logic             done_q;

  function automatic logic [RES_W-1:0] apply_op(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b,
                                                 input logic [7:0]       op);
    case (op)
      CH_MINUS: return a - b;
      CH_MUL:   return a * b;
      default:  return a + b;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      operand_q <= '0;
      pend_op_q <= CH_PLUS;
      idx_q     <= '0;
      len_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_res) begin
            result_q <= '0;
            done_q   <= 1'b0;
          end else if (clear_done) begin
            done_q <= 1'b0;
          end
          if (start) begin
            state_q   <= ST_EVAL;
            acc_q     <= '0;
            operand_q <= '0;
            pend_op_q <= CH_PLUS;
            idx_q     <= '0;
            len_q     <= len_in;
            done_q    <= 1'b0;
          end
        end
        ST_EVAL: begin
          if (is_digit(fetch_char)) begin
            // operand*10 as shifts keeps the arithmetic at RES_W bits
            operand_q <= (operand_q << 3) + (operand_q << 1) + RES_W'(fetch_char[3:0]);
          end else begin
            acc_q     <= apply_op(acc_q, operand_q, pend_op_q);
            pend_op_q <= fetch_char;
            operand_q <= '0;
          end
          if (idx_q + LEN_W'(1) == len_q) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + LEN_W'(1);
          end
        end
        ST_DONE: begin
          result_q <= apply_op(acc_q, operand_q, pend_op_q);
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fetch_idx = idx_q[IDX_W-1:0];
  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/calc_key_ctrl.sv
// Keypad front end: cursor movement, key decode and input-buffer editing; hands
// the buffer to calc_eval when "=" is pressed.
module calc_key_ctrl
  import calc_key_ctrl_pkg::*;
#(
  parameter int STR_LEN = STR_LEN_DEF,
  parameter int RES_W   = RES_W_DEF
) (
  input  logic                 clk_in,
  input  logic                 sys_rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  output logic [3:0]           cursor_x,
  output logic [3:0]           cursor_y,
  output logic [STR_LEN*8-1:0] disp_str_flat,
  output logic [RES_W-1:0]     result,
  output logic                 calc_done,
  output logic                 busy
);

  localparam int LEN_W = $clog2(STR_LEN + 1);
  localparam int IDX_W = (STR_LEN > 1) ? $clog2(STR_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(STR_LEN);

  logic [1:0]       cur_x_q, cur_x_d;
  logic [1:0]       cur_y_q, cur_y_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       buf_q [STR_LEN];
  logic [7:0]       buf_d [STR_LEN];

  logic [7:0]       key;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] del_idx;
  logic [IDX_W-1:0] fetch_idx;
  logic [7:0]       fetch_char;
  logic             start;
  logic             clear_res;
  logic             clear_done;

  assign key     = key_at(cur_y_q, cur_x_q);
  assign wr_idx  = len_q[IDX_W-1:0];
  assign del_idx = wr_idx - IDX_W'(1);

  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    len_d      = len_q;
    buf_d      = buf_q;
    start      = 1'b0;
    clear_res  = 1'b0;
    clear_done = 1'b0;
    // One action per cycle, sel first; everything is frozen while evaluating.
    if (!busy) begin
      if (btn_sel) begin
        if (key == CH_C) begin
          for (int k = 0; k < STR_LEN; k++) buf_d[k] = CH_SPACE;
          len_d     = '0;
          clear_res = 1'b1;
        end else if (key == CH_B) begin
          if (len_q != '0) begin
            buf_d[del_idx] = CH_SPACE;
            len_d          = len_q - LEN_W'(1);
            clear_done     = 1'b1;
          end
        end else if (key == CH_EQ) begin
          start = (len_q != '0);
        end else if (len_q != LEN_MAX) begin
          buf_d[wr_idx] = key;
          len_d         = len_q + LEN_W'(1);
          clear_done    = 1'b1;
        end
      end else if (btn_up) begin
        cur_y_d = cur_y_q - 2'd1;
      end else if (btn_down) begin
        cur_y_d = cur_y_q + 2'd1;
      end else if (btn_left) begin
        cur_x_d = cur_x_q - 2'd1;
      end else if (btn_right) begin
        cur_x_d = cur_x_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      len_q   <= '0;
      for (int k = 0; k < STR_LEN; k++) buf_q[k] <= CH_SPACE;
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STR_LEN; gi++) begin : g_flat
      assign disp_str_flat[gi*8 +: 8] = buf_q[gi];
    end
  endgenerate

  assign fetch_char = buf_q[fetch_idx];
  assign cursor_x   = {2'b00, cur_x_q};
  assign cursor_y   = {2'b00, cur_y_q};

  calc_eval #(
    .STR_LEN (STR_LEN),
    .RES_W   (RES_W)
  ) u_eval (
    .clk        (clk_in),
    .srst       (sys_rst),
    .start      (start),
    .clear_res  (clear_res),
    .clear_done (clear_done),
    .len_in     (len_q),
    .fetch_idx  (fetch_idx),
    .fetch_char (fetch_char),
    .result     (result),
    .done       (calc_done),
    .busy       (busy)
  );

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Directed plus random button sequences against a string-level calculator model.
module tb_calc_key_ctrl;

  localparam int STR_LEN = 32;
  localparam int RES_W   = 24;
  localparam longint MOD = 64'd1 << RES_W;

  logic                 clk_in = 1'b0;
  logic                 sys_rst = 1'b1;
  logic                 btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic                 btn_sel = 1'b0;
  logic [3:0]           cursor_x, cursor_y;
  logic [STR_LEN*8-1:0] disp_str_flat;
  logic [RES_W-1:0]     result;
  logic                 calc_done, busy;

  calc_key_ctrl #(.STR_LEN(STR_LEN), .RES_W(RES_W)) dut (
    .clk_in        (clk_in),
    .sys_rst       (sys_rst),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_sel       (btn_sel),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .disp_str_flat (disp_str_flat),
    .result        (result),
    .calc_done     (calc_done),
    .busy          (busy)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: cursor, buffer as a character queue, last result and valid flag.
  int               m_x, m_y;
  byte unsigned     m_buf[$];
  logic [RES_W-1:0] m_res;
  bit               m_done;
  string            km[4] = '{"123+", "456-", "789*", "C0=B"};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int k = 0; k < STR_LEN; k++)
      f[k*8 +: 8] = (k < m_buf.size()) ? m_buf[k] : 8'h20;
    return f;
  endfunction

  function automatic longint m_apply(input longint a, input longint b, input byte unsigned op);
    case (op)
      8'h2D:   return (a - b + MOD) % MOD;
      8'h2A:   return (a * b) % MOD;
      default: return (a + b) % MOD;
    endcase
  endfunction

  function automatic logic [RES_W-1:0] m_eval();
    longint       acc = 0, opnd = 0;
    byte unsigned op = 8'h2B;
    foreach (m_buf[k]) begin
      if (m_buf[k] >= 8'h30 && m_buf[k] <= 8'h39) begin
        opnd = (opnd * 10 + longint'(m_buf[k] - 8'h30)) % MOD;
      end else begin
        acc  = m_apply(acc, opnd, op);
        op   = m_buf[k];
        opnd = 0;
      end
    end
    return RES_W'(m_apply(acc, opnd, op));
  endfunction

  task automatic m_reset();
    m_x = 0; m_y = 0; m_buf.delete(); m_res = '0; m_done = 1'b0;
  endtask

  task automatic drive(input bit s, input bit u, input bit d, input bit l, input bit r);
    btn_sel = s; btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    @(posedge clk_in); #1;
    btn_sel = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"},    cursor_x, m_x);
    chk({tag, ".y"},    cursor_y, m_y);
    chk({tag, ".buf"},  disp_str_flat, m_flat());
    chk({tag, ".res"},  result, m_res);
    chk({tag, ".done"}, calc_done, m_done);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  task automatic press(input bit s, input bit u, input bit d, input bit l, input bit r,
                       input string tag);
    byte unsigned k;
    bit           started = 0;
    int           n;
    logic [4:0]   junk;
    k = km[m_y][m_x];
    drive(s, u, d, l, r);
    if (s) begin
      case (k)
        8'h43: begin m_buf.delete(); m_res = '0; m_done = 0; end
        8'h42: if (m_buf.size() > 0) begin void'(m_buf.pop_back()); m_done = 0; end
        8'h3D: started = (m_buf.size() > 0);
        default: if (m_buf.size() < STR_LEN) begin m_buf.push_back(k); m_done = 0; end
      endcase
    end else if (u) m_y = (m_y + 3) % 4;
    else if (d)     m_y = (m_y + 1) % 4;
    else if (l)     m_x = (m_x + 3) % 4;
    else if (r)     m_x = (m_x + 1) % 4;
    $display("press %s sel=%0d up=%0d dn=%0d lt=%0d rt=%0d key=%c len=%0d",
             tag, s, u, d, l, r, k, m_buf.size());
    if (started) begin
      n = m_buf.size();
      // busy must cover exactly len+1 cycles, and buttons during it change nothing
      for (int c = 0; c <= n; c++) begin
        chk({tag, ".busy_on"}, busy, 1'b1);
        chk({tag, ".busy_buf"}, disp_str_flat, m_flat());
        chk({tag, ".busy_xy"}, {cursor_y, cursor_x}, {4'(m_y), 4'(m_x)});
        junk = 5'($urandom_range(0, 31));
        drive(junk[0], junk[1], junk[2], junk[3], junk[4]);
      end
      m_res  = m_eval();
      m_done = 1'b1;
      $display("eval len=%0d result=%0h", n, m_res);
    end
    check_all(tag);
  endtask

  task automatic move_to(input int row, input int col);
    for (int g = 0; g < 4 && m_y != row; g++) press(0, 0, 1, 0, 0, "mv_dn");
    for (int g = 0; g < 4 && m_x != col; g++) press(0, 0, 0, 0, 1, "mv_rt");
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (km[r][c] == s[i]) move_to(r, c);
      press(1, 0, 0, 0, 0, "key");
    end
  endtask

  initial begin
    logic [255:0] spaces;
    bit           s;
    logic [3:0]   dirs;
    spaces = {32{8'h20}};
    m_reset();
    repeat (3) @(posedge clk_in);
    #1 sys_rst = 1'b0;
    @(posedge clk_in); #1;
    chk("rst.x", cursor_x, 0);
    chk("rst.y", cursor_y, 0);
    chk("rst.buf", disp_str_flat, spaces);
    chk("rst.res", result, 0);
    chk("rst.done", calc_done, 0);
    chk("rst.busy", busy, 0);

    press(0, 0, 0, 1, 0, "left_wrap");
    chk("left_wrap.x3", cursor_x, 3);
    press(0, 1, 0, 0, 0, "up_wrap");
    chk("up_wrap.y3", cursor_y, 3);
    press(0, 1, 0, 1, 0, "up_left");
    chk("up_left.y", cursor_y, 2);
    chk("up_left.x", cursor_x, 3);

    type_str("12+34=");
    chk("eval46", result, 46);
    chk("eval46.done", calc_done, 1);
    type_str("C2+3*4=");
    chk("eval20", result, 20);
    type_str("C0-1=");
    chk("eval_wrap", result, 24'hFFFFFF);
    type_str("C");
    chk("clr.done", calc_done, 0);
    chk("clr.res", result, 0);
    type_str("5*=");
    chk("eval_trail", result, 0);
    chk("eval_trail.done", calc_done, 1);

    type_str("C1");
    for (int i = 0; i < 32; i++) press(1, 0, 0, 0, 0, "fill");
    chk("full.c31", disp_str_flat[31*8 +: 8], 8'h31);
    type_str("B");
    chk("bksp.c31", disp_str_flat[31*8 +: 8], 8'h20);
    chk("bksp.c30", disp_str_flat[30*8 +: 8], 8'h31);
    type_str("C");
    chk("clr_all.buf", disp_str_flat, spaces);

    // Abort an evaluation with reset while in EVAL.
    type_str("123");
    move_to(3, 2);
    drive(1, 0, 0, 0, 0);
    chk("abort.busy_on", busy, 1);
    sys_rst = 1'b1;
    @(posedge clk_in); #1;
    sys_rst = 1'b0;
    m_reset();
    chk("abort.busy", busy, 0);
    chk("abort.buf", disp_str_flat, spaces);
    chk("abort.xy", {cursor_y, cursor_x}, 8'h00);
    @(posedge clk_in); #1;
    check_all("abort.after");

    for (int t = 0; t < 300; t++) begin
      s    = 1'($urandom_range(0, 1));
      dirs = 4'($urandom_range(0, 15));
      press(s, dirs[0], dirs[1], dirs[2], dirs[3], "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_key_ctrl.md
CALC_KEY_CTRL -- requirements
Module: calc_key_ctrl

Interface
REQ-001 SHALL have parameter STR_LEN, default 32, meaning the number of characters in the input buffer.
REQ-002 SHALL have parameter RES_W, default 24, meaning the result width in bits.
REQ-003 SHALL have port clk_in  input  1  system clock; one clock domain only.
REQ-004 SHALL have port sys_rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports btn_up, btn_down, btn_left, btn_right  input  1 each  single-cycle, pre-debounced cursor pulses.
REQ-006 SHALL have port btn_sel  input  1  single-cycle pulse that presses the key under the cursor.
REQ-007 SHALL have ports cursor_x, cursor_y  output  4 each  cursor column and row, range 0..3.
REQ-008 SHALL have port disp_str_flat  output  STR_LEN*8  input buffer; char k is at bits [k*8 +: 8].
REQ-009 SHALL have port result  output  RES_W  result of the last evaluation, unsigned.
REQ-010 SHALL have port calc_done  output  1  result valid.
REQ-011 SHALL have port busy  output  1  high while an evaluation is running.

Function
REQ-012 SHALL use this key map, indexed (row, col): row0 "1","2","3","+"; row1 "4","5","6","-"; row2 "7","8","9","*"; row3 "C","0","=","B".
REQ-013 SHALL wrap each cursor axis modulo 4: left at x=0 gives x=3, right at x=3 gives x=0, up at y=0 gives y=3, down at y=3 gives y=0.
REQ-014 SHALL act on at most one button per cycle, priority sel > up > down > left > right; lower-priority pulses in that cycle are dropped.
REQ-015 SHALL ignore all buttons while busy=1.
REQ-016 SHALL keep a length counter len (0..STR_LEN); unused buffer positions SHALL read 0x20 (space).
REQ-017 Digit or operator key SHALL write its ASCII code at position len and increment len when len<STR_LEN; when len=STR_LEN the key is ignored.
REQ-018 "B" SHALL, when len>0, decrement len and set that position to 0x20; when len=0 it SHALL have no effect.
REQ-019 "C" SHALL set every buffer position to 0x20, set len=0, result=0 and calc_done=0.
REQ-020 Any accepted key other than "=" SHALL clear calc_done in the same cycle it takes effect.
REQ-021 "=" with len=0 SHALL be a no-op; with len>0 it SHALL start an evaluation.
REQ-022 SHALL implement the evaluation FSM IDLE -> EVAL -> DONE -> IDLE.
REQ-023 The "=" press SHALL move the FSM to EVAL on the next edge, with acc=0, operand=0, pending_op="+", and index i=0.
REQ-024 EVAL SHALL process one char per cycle, for i = 0..len-1:
- digit d: operand = operand*10 + d, modulo 2^RES_W;
- operator: acc = acc (pending_op) operand, then pending_op = operator, then operand = 0.
REQ-025 After char len-1 has been processed, the FSM SHALL enter DONE for one cycle.
REQ-026 DONE SHALL apply pending_op a final time, register result, set calc_done=1, and return to IDLE.
REQ-027 Latency: for an "=" pulse in cycle T, calc_done and result SHALL be visible from cycle T+len+2.
REQ-028 SHALL evaluate strictly left-to-right with no precedence: "2+3*4" = 20.
REQ-029 Arithmetic SHALL be unsigned modulo 2^RES_W: subtraction underflow wraps, and multiplication keeps the low RES_W bits.
REQ-030 Edge cases SHALL use operand 0 for the missing operand: leading operator applies to acc=0; consecutive operators apply operand 0; a trailing operator applies operand 0 ("5*" = 0).
REQ-031 busy SHALL be 1 exactly in EVAL and DONE.
REQ-032 The buffer, len and cursor SHALL be unchanged by an evaluation.

Reset
REQ-033 sys_rst SHALL set cursor (0,0), buffer all 0x20, len=0, result=0, calc_done=0, busy=0 and FSM=IDLE.
REQ-034 sys_rst asserted during EVAL or DONE SHALL abort the evaluation with all state per REQ-033; no partial result SHALL appear.

Structure
REQ-035 A shared package SHALL hold: the key-map table, the ASCII constants (space, "0", "+", "-", "*", "=", "C", "B"), STR_LEN and RES_W defaults, and the FSM state encoding.
REQ-036 The sequential evaluator (REQ-022 to REQ-030) SHALL be one sub-module, calc_eval, with start/len/char-fetch/result/done ports.
REQ-037 Key decode, cursor and buffer editing SHALL stay in calc_key_ctrl.

Verification
REQ-038 Reset check: release sys_rst -> cursor (0,0), disp_str_flat = 256 bits of 0x20 repeated, result=0, calc_done=0, busy=0.
REQ-039 Cursor wrap and priority:
- left at (0,0) -> x=3;
- up at y=0 -> y=3;
- btn_up and btn_left in the same cycle -> only y changes.
REQ-040 Basic evaluation: enter "12+34" then "=" -> busy for 6 cycles, result=46, and calc_done=1 at T+7.
REQ-041 Precedence and wrap:
- "2+3*4=" -> 20;
- "0-1=" -> 0xFFFFFF;
- "5*=" -> 0.
REQ-042 Buffer limits: 33 digit presses -> len=32, 33rd ignored; "B" -> char 31 = 0x20; "C" -> all spaces and calc_done=0.
REQ-043 Busy and reset:
- buttons pulsed during busy -> no cursor or buffer change;
- sys_rst during EVAL -> FSM IDLE next cycle and REQ-033 values.
